// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        BUSY    = 3'd3,
        DONE    = 3'd4,
        RECOVER = 3'd5
    } state_e;

    localparam logic [7:0] RST_REG_NONE    = 8'h00;
    localparam logic [7:0] RST_REG_START   = 8'h02;
    localparam logic [7:0] RST_REG_RECOVER = 8'hFF;

    // Shared phase counter; wide enough for the largest allowed timeout.
    localparam int CNT_W = 20;

    typedef struct packed {
        logic       slave;
        logic [6:0] addr;
        logic       rw;
    } cmd_entry_t;

    localparam int CMD_W = $bits(cmd_entry_t);

    function automatic logic [7:0] cntrl_of(input cmd_entry_t e);
        return {e.addr, e.rw};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer_if
// Description : Host command valid/ready channel into the I2C command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic       cmd_slave;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_rw,
        output cmd_slave,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_rw,
        input  cmd_slave,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_fifo
// Description : Synchronous power-of-two FIFO with full/empty/level status.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push_i,
    input  wire logic                   pop_i,
    input  wire logic [WIDTH-1:0]       wdata_i,
    output logic      [WIDTH-1:0]       rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic      [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (level_q == C_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                level_q <= level_q + 1'b1;
            end else if (w_pop && !w_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer
// Description : Buffers host I2C commands, strobes the module, watches the bus
//               for STOP and recovers on timeout. Optional I2C_SEQ_STATS_EN
//               adds saturating done/err counters.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int RECOVER_CYC = 16,
    parameter int START_CYC   = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    i2c_cmd_sequencer_if.slave                 cmd,
    input  wire logic                          scl_mon,
    input  wire logic                          sda_mon,
    output logic                               select_,
    output logic      [7:0]                    cntrl_reg,
    output logic      [7:0]                    rst_reg,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic      [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef I2C_SEQ_STATS_EN
    ,
    output logic      [15:0]                   stat_done_cnt,
    output logic      [15:0]                   stat_err_cnt
`endif
);
    localparam logic [CNT_W-1:0] C_START_LAST   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_RECOVER_LAST = CNT_W'(RECOVER_CYC - 1);

    // Bus monitor: flops reset high so an idle bus never looks like an edge.
    logic scl_s1_q, scl_s2_q;
    logic sda_s1_q, sda_s2_q, sda_s3_q;
    logic w_stop, w_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_s3_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_mon;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_mon;
            sda_s2_q <= sda_s1_q;
            sda_s3_q <= sda_s2_q;
        end
    end

    assign w_stop  = scl_s2_q && sda_s2_q && !sda_s3_q;
    assign w_start = scl_s2_q && !sda_s2_q && sda_s3_q;

    cmd_entry_t w_push_entry;
    cmd_entry_t w_fifo_rdata;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_fifo_pop;

    assign w_push_entry  = {cmd.cmd_slave, cmd.cmd_addr, cmd.cmd_rw};
    assign cmd.cmd_ready = !w_fifo_full;

    i2c_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd.cmd_valid),
        .pop_i   (w_fifo_pop),
        .wdata_i (w_push_entry),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .level_o (fifo_level)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_entry_t       entry_q, entry_d;
    logic [7:0]       cntrl_q, cntrl_d;
    logic             select_q, select_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            entry_q  <= '0;
            cntrl_q  <= 8'h00;
            select_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            entry_q  <= entry_d;
            cntrl_q  <= cntrl_d;
            select_q <= select_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        entry_d    = entry_q;
        cntrl_d    = cntrl_q;
        select_d   = select_q;
        w_fifo_pop = 1'b0;
        rst_reg    = RST_REG_NONE;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!w_fifo_empty) begin
                    w_fifo_pop = 1'b1;
                    entry_d    = w_fifo_rdata;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cnt_d    = '0;
                cntrl_d  = cntrl_of(entry_q);
                select_d = entry_q.slave;
                state_d  = START;
            end
            START: begin
                rst_reg = RST_REG_START;
                if (cnt_q == C_START_LAST) begin
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // STOP outranks both a repeated START and the timeout.
                if (w_stop) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (w_start) begin
                    cnt_d = '0;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    cnt_d    = '0;
                    select_d = 1'b1;
                    state_d  = RECOVER;
                end
            end
            DONE: begin
                done    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            RECOVER: begin
                rst_reg = RST_REG_RECOVER;
                err     = (cnt_q == '0);
                if (cnt_q == C_RECOVER_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign cntrl_reg = cntrl_q;
    assign select_   = select_q;

`ifdef I2C_SEQ_STATS_EN
    logic [15:0] stat_done_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done_q <= '0;
            stat_err_q  <= '0;
        end else begin
            if (done && (stat_done_q != 16'hFFFF)) begin
                stat_done_q <= stat_done_q + 16'd1;
            end
            if (err && (stat_err_q != 16'hFFFF)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign stat_done_cnt = stat_done_q;
    assign stat_err_cnt  = stat_err_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_cmd_sequencer
// Description : Directed self-checking bench for i2c_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_sequencer;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 100;
    localparam int RECOVER_CYC = 16;
    localparam int START_CYC   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_mon;
    logic       sda_mon;
    logic       select_;
    logic [7:0] cntrl_reg;
    logic [7:0] rst_reg;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] fifo_level;
`ifdef I2C_SEQ_STATS_EN
    logic [15:0] stat_done_cnt;
    logic [15:0] stat_err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    i2c_cmd_sequencer_if cmd_if ();

    i2c_cmd_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RECOVER_CYC (RECOVER_CYC),
        .START_CYC   (START_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .scl_mon    (scl_mon),
        .sda_mon    (sda_mon),
        .select_    (select_),
        .cntrl_reg  (cntrl_reg),
        .rst_reg    (rst_reg),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fifo_level (fifo_level)
`ifdef I2C_SEQ_STATS_EN
        ,
        .stat_done_cnt (stat_done_cnt),
        .stat_err_cnt  (stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [6:0] a, input logic r);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_slave = s;
        cmd_if.cmd_addr  = a;
        cmd_if.cmd_rw    = r;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Drive a STOP on the bus and expect exactly one done pulse then IDLE.
    task automatic do_stop(input string name);
        bit seen = 1'b0;
        scl_mon = 1'b0; tick();
        sda_mon = 1'b0; tick();
        scl_mon = 1'b1; tick();
        sda_mon = 1'b1;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done got no pulse within 10 cycles exp pulse", name);
        end else begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_after_done got done=%b busy=%b exp done=0 busy=0", name, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        scl_mon = 1'b1;
        sda_mon = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_slave = 1'b0;
        cmd_if.cmd_addr  = 7'h00;
        cmd_if.cmd_rw    = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd_if.cmd_ready, select_, busy, done, err} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flags got ready,sel,busy,done,err=%b exp 11000",
                     {cmd_if.cmd_ready, select_, busy, done, err});
        end
        checks++;
        if (cntrl_reg !== 8'h00 || rst_reg !== 8'h00 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_regs got cntrl=%h rst_reg=%h level=%0d exp 00 00 0",
                     cntrl_reg, rst_reg, fifo_level);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int bad = 0;
        push(1'b0, 7'h50, 1'b0);
        checks++;
        if (fifo_level !== 3'd1 || rst_reg !== 8'h00) begin
            errors++;
            $display("FAIL basic_after_push got level=%0d rst_reg=%h exp 1 00", fifo_level, rst_reg);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || rst_reg !== 8'h00 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL basic_load got busy=%b rst_reg=%h level=%0d exp 1 00 0", busy, rst_reg, fifo_level);
        end
        tick();
        checks++;
        if (cntrl_reg !== 8'hA0 || select_ !== 1'b0) begin
            errors++;
            $display("FAIL basic_cntrl got cntrl=%h sel=%b exp A0 0", cntrl_reg, select_);
        end
        for (int i = 0; i < START_CYC; i++) begin
            if (rst_reg !== 8'h02 || busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_start_strobe got %0d bad cycles exp 0", bad);
        end
        checks++;
        if (rst_reg !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got rst_reg=%h busy=%b exp 00 1", rst_reg, busy);
        end
        do_stop("basic");
    endtask

    task automatic test_timeout();
        int bad = 0;
        push(1'b0, 7'h3C, 1'b1);
        tick();
        tick();
        checks++;
        if (rst_reg !== 8'h02 || cntrl_reg !== 8'h79) begin
            errors++;
            $display("FAIL timeout_start got rst_reg=%h cntrl=%h exp 02 79", rst_reg, cntrl_reg);
        end
        repeat (START_CYC) tick();
        checks++;
        if (select_ !== 1'b0 || busy !== 1'b1 || rst_reg !== 8'h00) begin
            errors++;
            $display("FAIL timeout_busy got sel=%b busy=%b rst_reg=%h exp 0 1 00", select_, busy, rst_reg);
        end
        repeat (TIMEOUT_CYC - 1) tick();
        checks++;
        if (err !== 1'b0 || rst_reg !== 8'h00) begin
            errors++;
            $display("FAIL timeout_early got err=%b rst_reg=%h exp 0 00", err, rst_reg);
        end
        tick();
        checks++;
        if (err !== 1'b1 || rst_reg !== 8'hFF || select_ !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err got err=%b rst_reg=%h sel=%b exp 1 FF 1", err, rst_reg, select_);
        end
        for (int i = 1; i < RECOVER_CYC; i++) begin
            tick();
            if (rst_reg !== 8'hFF || err !== 1'b0 || select_ !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_recover got %0d bad cycles exp 0", bad);
        end
        tick();
        checks++;
        if (rst_reg !== 8'h00 || busy !== 1'b0 || select_ !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle got rst_reg=%h busy=%b sel=%b exp 00 0 1", rst_reg, busy, select_);
        end
    endtask

    task automatic test_repeated_start();
        int errs = 0;
        push(1'b1, 7'h22, 1'b0);
        tick();
        tick();
        checks++;
        if (cntrl_reg !== 8'h44 || select_ !== 1'b1) begin
            errors++;
            $display("FAIL rstart_cntrl got cntrl=%h sel=%b exp 44 1", cntrl_reg, select_);
        end
        repeat (START_CYC) tick();
        for (int i = 0; i < 88; i++) begin
            tick();
            if (err !== 1'b0) errs++;
        end
        sda_mon = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (err !== 1'b0) errs++;
        end
        checks++;
        if (errs != 0 || busy !== 1'b1 || rst_reg !== 8'h00) begin
            errors++;
            $display("FAIL rstart_no_timeout got err_cycles=%0d busy=%b rst_reg=%h exp 0 1 00", errs, busy, rst_reg);
        end
        sda_mon = 1'b1;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                tick();
                if (done === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL rstart_done got no pulse within 10 cycles exp pulse");
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_c [4] = '{8'h23, 8'h24, 8'h27, 8'h29};
        logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        push(1'b0, 7'h10, 1'b0);
        repeat (2 + START_CYC) tick();
        push(1'b0, 7'h11, 1'b1);
        push(1'b1, 7'h12, 1'b0);
        push(1'b0, 7'h13, 1'b1);
        checks++;
        if (fifo_level !== 3'd3 || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_three got level=%0d ready=%b exp 3 1", fifo_level, cmd_if.cmd_ready);
        end
        push(1'b1, 7'h14, 1'b1);
        checks++;
        if (fifo_level !== 3'd4 || cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full got level=%0d ready=%b exp 4 0", fifo_level, cmd_if.cmd_ready);
        end
        push(1'b0, 7'h7F, 1'b0);
        checks++;
        if (fifo_level !== 3'd4 || cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_reject got level=%0d ready=%b exp 4 0", fifo_level, cmd_if.cmd_ready);
        end
        do_stop("fifo_first");
        for (int k = 0; k < 4; k++) begin
            bit seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                tick();
                if (rst_reg === 8'h02) seen = 1'b1;
            end
            checks++;
            if (!seen || cntrl_reg !== exp_c[k] || select_ !== exp_s[k]) begin
                errors++;
                $display("FAIL fifo_order_%0d got strobe=%b cntrl=%h sel=%b exp 1 %h %b",
                         k, seen, cntrl_reg, select_, exp_c[k], exp_s[k]);
            end
            repeat (START_CYC) tick();
            do_stop("fifo_entry");
        end
        checks++;
        if (fifo_level !== 3'd0 || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_drained got level=%0d ready=%b exp 0 1", fifo_level, cmd_if.cmd_ready);
        end
    endtask

`ifdef I2C_SEQ_STATS_EN
    task automatic test_stats();
        checks++;
        if (stat_done_cnt !== 16'd7 || stat_err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stats got done=%0d err=%0d exp 7 1", stat_done_cnt, stat_err_cnt);
        end
    endtask
`endif

    task automatic test_reset_in_recover();
        bit seen = 1'b0;
        push(1'b0, 7'h30, 1'b0);
        repeat (2 + START_CYC) tick();
        push(1'b0, 7'h31, 1'b0);
        for (int n = 0; n < 150 && !seen; n++) begin
            tick();
            if (rst_reg === 8'hFF) seen = 1'b1;
        end
        tick();
        tick();
        checks++;
        if (!seen || rst_reg !== 8'hFF || select_ !== 1'b1 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL rrec_in_recover got seen=%b rst_reg=%h sel=%b level=%0d exp 1 FF 1 1",
                     seen, rst_reg, select_, fifo_level);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (rst_reg !== 8'h00 || fifo_level !== 3'd0 || select_ !== 1'b1 ||
            busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || cntrl_reg !== 8'h00) begin
            errors++;
            $display("FAIL rrec_async got rst_reg=%h level=%0d sel=%b busy=%b ready=%b cntrl=%h exp 00 0 1 0 1 00",
                     rst_reg, fifo_level, select_, busy, cmd_if.cmd_ready, cntrl_reg);
        end
`ifdef I2C_SEQ_STATS_EN
        checks++;
        if (stat_done_cnt !== 16'd0 || stat_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got done=%0d err=%0d exp 0 0", stat_done_cnt, stat_err_cnt);
        end
`endif
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_repeated_start();
        test_fifo_full();
`ifdef I2C_SEQ_STATS_EN
        test_stats();
`endif
        test_reset_in_recover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
